// File: rtl/partsel_lane_regfile.sv
// Small register file of packed-lane entries accessed through a signed, possibly
// out-of-range part-select, with WRITE/READ/CLEAR, a two-step ACCUM and byte-reversed readback.
module partsel_lane_regfile #(
    parameter int DEPTH   = 4,
    parameter int NLANES  = 2,
    parameter int LANE_W  = 32,
    parameter int SLICE_W = 8,
    parameter int OFF_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [$clog2(DEPTH)-1:0]   req_addr,
    input  logic [$clog2(NLANES)-1:0]  req_lane,
    input  logic signed [OFF_W-1:0]    req_off,
    input  logic [SLICE_W-1:0]         req_data,
    output logic                       rsp_valid,
    output logic [SLICE_W-1:0]         rsp_data,
    output logic [NLANES*LANE_W-1:0]   rsp_word,
    output logic [NLANES*LANE_W-1:0]   rsp_swapped
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(NLANES);
    localparam int LIDX = $clog2(LANE_W);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {IDLE, ACC_RD, ACC_WR} state_t;
    typedef logic [NLANES-1:0][LANE_W-1:0] entry_t;

    // No reset on the storage: contents start at zero and survive rst_n.
    bit [NLANES-1:0][LANE_W-1:0] mem [DEPTH];

    state_t                   state, state_next;
    logic [AW-1:0]            cap_addr;
    logic [LW-1:0]            cap_lane;
    logic signed [OFF_W-1:0]  cap_off;
    logic [SLICE_W-1:0]       cap_data;
    logic [SLICE_W-1:0]       acc_hold;
    logic [SLICE_W-1:0]       acc_sum;
    logic                     xfer;
    entry_t                   cur_entry, idle_entry, acc_entry;
    logic                     mem_we;
    logic [AW-1:0]            mem_waddr;
    entry_t                   mem_wdata;

    // Out-of-range slice bits read as zero and never reach a neighbouring lane.
    function automatic logic [SLICE_W-1:0] get_slice(input logic [LANE_W-1:0] lane_val,
                                                     input logic signed [OFF_W-1:0] off);
        logic [SLICE_W-1:0] s;
        int pos;
        s = '0;
        for (int k = 0; k < SLICE_W; k++) begin
            pos = int'(off) + k;
            if (pos >= 0 && pos < LANE_W) s[k] = lane_val[pos[LIDX-1:0]];
        end
        return s;
    endfunction

    function automatic logic [LANE_W-1:0] put_slice(input logic [LANE_W-1:0] lane_val,
                                                    input logic signed [OFF_W-1:0] off,
                                                    input logic [SLICE_W-1:0] val);
        logic [LANE_W-1:0] r;
        int pos;
        r = lane_val;
        for (int k = 0; k < SLICE_W; k++) begin
            pos = int'(off) + k;
            if (pos >= 0 && pos < LANE_W) r[pos[LIDX-1:0]] = val[k];
        end
        return r;
    endfunction

    assign req_ready   = (state == IDLE) && rst_n;
    assign xfer        = req_valid && req_ready;
    assign acc_sum     = acc_hold + cap_data;
    assign rsp_swapped = {<<8{rsp_word}};

    always_comb begin
        cur_entry  = mem[req_addr];
        idle_entry = cur_entry;
        case (req_op)
            OP_WRITE: idle_entry[req_lane] = put_slice(cur_entry[req_lane], req_off, req_data);
            OP_CLEAR: idle_entry = '0;
            default:  idle_entry = cur_entry;
        endcase
        acc_entry = mem[cap_addr];
        acc_entry[cap_lane] = put_slice(acc_entry[cap_lane], cap_off, acc_sum);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = idle_entry;
        if (state == ACC_WR) begin
            mem_we    = 1'b1;
            mem_waddr = cap_addr;
            mem_wdata = acc_entry;
        end else if (xfer && (req_op == OP_WRITE || req_op == OP_CLEAR)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer && req_op == OP_ACCUM) state_next = ACC_RD;
            ACC_RD:  state_next = ACC_WR;
            ACC_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap_addr <= '0;
            cap_lane <= '0;
            cap_off  <= '0;
            cap_data <= '0;
            acc_hold <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                cap_addr <= req_addr;
                cap_lane <= req_lane;
                cap_off  <= req_off;
                cap_data <= req_data;
            end
            if (state == ACC_RD) acc_hold <= get_slice(mem[cap_addr][cap_lane], cap_off);
        end
    end

    // Responses reflect the entry after the operation and hold while rsp_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_word  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ACC_WR) begin
                rsp_valid <= 1'b1;
                rsp_word  <= acc_entry;
                rsp_data  <= get_slice(acc_entry[cap_lane], cap_off);
            end else if (xfer && req_op != OP_ACCUM) begin
                rsp_valid <= 1'b1;
                rsp_word  <= idle_entry;
                rsp_data  <= get_slice(idle_entry[req_lane], req_off);
            end
        end
    end

endmodule

// File: tb/tb_partsel_lane_regfile.sv
// Directed self-checking bench for partsel_lane_regfile with hand-computed expectations.
module tb_partsel_lane_regfile;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [1:0]  req_addr = '0;
    logic [0:0]  req_lane = '0;
    logic signed [6:0] req_off = '0;
    logic [7:0]  req_data = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [63:0] rsp_word;
    logic [63:0] rsp_swapped;

    int nChecks = 0;
    int nFails  = 0;

    partsel_lane_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_lane(req_lane), .req_off(req_off), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_word(rsp_word), .rsp_swapped(rsp_swapped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, let it be accepted, and return #1 after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input int addr, input int lane,
                                 input int off, input logic [7:0] data);
        @(negedge clk);
        req_op    = op;
        req_addr  = 2'(addr);
        req_lane  = 1'(lane);
        req_off   = 7'(off);
        req_data  = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Accumulate request: counts not-ready cycles until the response appears.
    task automatic accumulate(input int addr, input int lane, input int off,
                              input logic [7:0] data, output int busy, output logic [7:0] res);
        int waited;
        busy = 0;
        waited = 0;
        applyStimulus(OP_ACCUM, addr, lane, off, data);
        while (!rsp_valid && waited < 10) begin
            if (!req_ready) busy++;
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("accum_timeout", 64'(waited < 10), 64'd1);
        checkOutput("accum_ready_at_rsp", 64'(req_ready), 64'd1);
        res = rsp_data;
    endtask

    initial begin
        int busy;
        logic [7:0] res;

        rst_n = 1'b0;
        #12;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_word", rsp_word, 64'd0);
        checkOutput("reset_rsp_swapped", rsp_swapped, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 64'(req_ready), 64'd1);

        applyStimulus(OP_READ, 3, 1, 0, 8'h00);
        checkOutput("powerup_valid", 64'(rsp_valid), 64'd1);
        checkOutput("powerup_data", 64'(rsp_data), 64'h00);
        checkOutput("powerup_word", rsp_word, 64'd0);

        applyStimulus(OP_WRITE, 1, 1, 8, 8'hA5);
        checkOutput("wr_a1_data", 64'(rsp_data), 64'hA5);
        checkOutput("wr_a1_word", rsp_word, 64'h0000A500_00000000);
        applyStimulus(OP_READ, 1, 1, 8, 8'h00);
        checkOutput("rd_a1_data", 64'(rsp_data), 64'hA5);
        checkOutput("rd_a1_word", rsp_word, 64'h0000A500_00000000);
        checkOutput("rd_a1_swapped", rsp_swapped, 64'h00000000_00A50000);

        applyStimulus(OP_WRITE, 0, 0, -4, 8'hFF);
        checkOutput("wr_neg_data", 64'(rsp_data), 64'hF0);
        checkOutput("wr_neg_word", rsp_word, 64'h00000000_0000000F);
        applyStimulus(OP_READ, 0, 0, -4, 8'h00);
        checkOutput("rd_neg_data", 64'(rsp_data), 64'hF0);
        applyStimulus(OP_WRITE, 0, 0, 28, 8'hFF);
        checkOutput("wr_top_data", 64'(rsp_data), 64'h0F);
        checkOutput("wr_top_word", rsp_word, 64'h00000000_F000000F);

        accumulate(2, 0, 0, 8'hF0, busy, res);
        checkOutput("acc1_busy", 64'(busy), 64'd2);
        checkOutput("acc1_data", 64'(res), 64'hF0);
        checkOutput("acc1_word", rsp_word, 64'h00000000_000000F0);
        @(posedge clk);
        #1;
        checkOutput("rsp_pulse_one_cycle", 64'(rsp_valid), 64'd0);
        checkOutput("rsp_hold_data", 64'(rsp_data), 64'hF0);
        accumulate(2, 0, 0, 8'h20, busy, res);
        checkOutput("acc2_busy", 64'(busy), 64'd2);
        checkOutput("acc2_wrap_data", 64'(res), 64'h10);
        checkOutput("acc2_word", rsp_word, 64'h00000000_00000010);

        applyStimulus(OP_ACCUM, 2, 0, 0, 8'h05);
        checkOutput("acc3_busy", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midacc_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midacc_rsp_word", rsp_word, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("midacc_rsp_valid2", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midacc_ready", 64'(req_ready), 64'd1);
        applyStimulus(OP_READ, 2, 0, 0, 8'h00);
        checkOutput("abandoned_acc_data", 64'(rsp_data), 64'h10);
        checkOutput("abandoned_acc_word", rsp_word, 64'h00000000_00000010);
        applyStimulus(OP_READ, 0, 0, 0, 8'h00);
        checkOutput("mem_survives_reset", rsp_word, 64'h00000000_F000000F);

        applyStimulus(OP_CLEAR, 1, 0, 0, 8'h00);
        checkOutput("clear_data", 64'(rsp_data), 64'h00);
        checkOutput("clear_word", rsp_word, 64'd0);
        applyStimulus(OP_READ, 1, 1, 8, 8'h00);
        checkOutput("rd_cleared_data", 64'(rsp_data), 64'h00);
        checkOutput("rd_cleared_word", rsp_word, 64'd0);

        // Back-to-back write then read of the same slice, valid held high.
        @(negedge clk);
        req_op = OP_WRITE; req_addr = 2'd3; req_lane = 1'b1; req_off = 7'sd4; req_data = 8'h3C;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_wr_ready", 64'(req_ready), 64'd1);
        checkOutput("b2b_wr_data", 64'(rsp_data), 64'h3C);
        @(negedge clk);
        req_op = OP_READ; req_data = 8'h00;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("b2b_rd_valid", 64'(rsp_valid), 64'd1);
        checkOutput("b2b_rd_data", 64'(rsp_data), 64'h3C);
        checkOutput("b2b_rd_word", rsp_word, 64'h000003C0_00000000);

        // Fields without req_valid must be ignored.
        @(negedge clk);
        req_op = OP_CLEAR; req_addr = 2'd3;
        @(posedge clk);
        #1;
        checkOutput("idle_no_rsp", 64'(rsp_valid), 64'd0);
        applyStimulus(OP_READ, 3, 1, 4, 8'h00);
        checkOutput("idle_no_effect", 64'(rsp_data), 64'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
